// File: rtl/circuit.sv
// Enable-gated signed accumulator with saturating two's-complement arithmetic.
// y is driven straight from the accumulator register.
module circuit #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DATA_W-1:0] x,
  output logic [DATA_W-1:0] y
);

  localparam logic [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  logic [DATA_W-1:0] r_acc;
  logic [DATA_W:0]   w_sum;
  logic              w_ovf_pos;
  logic              w_ovf_neg;
  logic [DATA_W-1:0] w_next;

  always_comb begin
    w_sum = {r_acc[DATA_W-1], r_acc} + {x[DATA_W-1], x};
    // Overflow only when both operands share a sign the truncated sum lacks.
    w_ovf_pos = ~r_acc[DATA_W-1] & ~x[DATA_W-1] &  w_sum[DATA_W-1];
    w_ovf_neg =  r_acc[DATA_W-1] &  x[DATA_W-1] & ~w_sum[DATA_W-1];
    if (w_ovf_pos)
      w_next = SAT_MAX;
    else if (w_ovf_neg)
      w_next = SAT_MIN;
    else
      w_next = w_sum[DATA_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst)
      r_acc <= '0;
    else if (en)
      r_acc <= w_next;
  end

  assign y = r_acc;

endmodule

// File: tb/tb_circuit.sv
// Directed-vector and reference-model bench for the saturating accumulator.
module tb_circuit;

  typedef struct {
    logic        rst;
    logic        en;
    logic [31:0] x;
    logic [31:0] exp_y;
    string       name;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        en;
  logic [31:0] x;
  logic [31:0] y;

  int unsigned n_checks;
  int unsigned n_errors;
  vec_t        vecs[$];

  circuit #(.DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .x   (x),
    .y   (y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: y=%h expected %h", name, got, exp);
    end
  endtask

  function automatic void addv(input logic r, input logic e, input logic [31:0] xv,
                               input logic [31:0] ey, input string nm);
    vec_t v;
    v.rst = r; v.en = e; v.x = xv; v.exp_y = ey; v.name = nm;
    vecs.push_back(v);
  endfunction

  // Drive on the falling edge, sample 1 time unit after the rising edge.
  task automatic step(input logic r, input logic e, input logic [31:0] xv);
    @(negedge clk);
    rst = r; en = e; x = xv;
    @(posedge clk);
    #1;
  endtask

  initial begin
    longint model;
    int     xs;
    logic   r, e;

    n_checks = 0;
    n_errors = 0;
    rst = 1'b0; en = 1'b0; x = '0;

    // Reset held two cycles with en=1, then one idle cycle after release
    addv(1, 1, 32'd5, 32'd0, "rst_hold0");
    addv(1, 1, 32'd5, 32'd0, "rst_hold1");
    addv(0, 0, 32'd5, 32'd0, "rst_after");
    // Basic accumulate, en every other cycle
    addv(0, 1, 32'd3,         32'd3,          "acc_p3");
    addv(0, 0, 32'd3,         32'd3,          "hold_3");
    addv(0, 1, -32'sd7,       -32'sd4,        "acc_m7");
    addv(0, 0, 32'd0,         -32'sd4,        "hold_m4");
    addv(0, 1, 32'd10,        32'd6,          "acc_p10");
    addv(0, 0, 32'd10,        32'd6,          "hold_6a");
    addv(0, 1, 32'd0,         32'd6,          "acc_0");
    addv(0, 0, 32'd0,         32'd6,          "hold_6b");
    // Disabled: x toggles, y must not move
    addv(0, 0, 32'd19,        32'd6,          "ign0");
    addv(0, 0, -32'sd19,      32'd6,          "ign1");
    addv(0, 0, 32'd12,        32'd6,          "ign2");
    addv(0, 0, 32'hxxxxxxxx,  32'd6,          "ign_x");
    addv(0, 0, -32'sd19,      32'd6,          "ign4");
    // Positive saturation, back-to-back enables
    addv(1, 0, 32'd0,         32'd0,          "rst_pos");
    addv(0, 1, 32'h7FFFFFF0,  32'h7FFFFFF0,   "pre_pos");
    addv(0, 1, 32'h00000020,  32'h7FFFFFFF,   "sat_pos");
    addv(0, 1, -32'sd1,       32'h7FFFFFFE,   "dec_max");
    addv(0, 1, 32'd1,         32'h7FFFFFFF,   "exact_max");
    addv(0, 1, 32'h7FFFFFFF,  32'h7FFFFFFF,   "sat_pos_big");
    // Negative saturation
    addv(1, 1, 32'd9,         32'd0,          "rst_neg");
    addv(0, 1, 32'h80000000,  32'h80000000,   "pre_neg");
    addv(0, 1, -32'sd5,       32'h80000000,   "sat_neg");
    addv(0, 1, 32'd5,         32'h80000005,   "inc_min");
    addv(0, 1, 32'h80000000,  32'h80000000,   "sat_neg_big");
    // Reaching MIN exactly without clamping, then mixed-sign no overflow
    addv(1, 0, 32'd0,         32'd0,          "rst_min");
    addv(0, 1, -32'sd1,       32'hFFFFFFFF,   "m1");
    addv(0, 1, 32'h80000001,  32'h80000000,   "exact_min");
    addv(0, 1, 32'h7FFFFFFF,  32'hFFFFFFFF,   "mixed");
    // Reset mid-run then resume from zero
    addv(1, 1, 32'd100,       32'd0,          "rst_mid");
    addv(0, 1, 32'd4,         32'd4,          "resume");

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].en, vecs[i].x);
      check(vecs[i].name, y, vecs[i].exp_y);
    end

    // Random stream against a wide-integer clamp model, reset at sample 50
    step(1'b1, 1'b0, '0);
    model = 0;
    check("rand_rst", y, 32'd0);
    for (int i = 0; i < 100; i++) begin
      xs = int'($urandom_range(38)) - 19;
      r  = (i == 50);
      e  = (i % 2 == 0);
      step(r, e, 32'(xs));
      if (r)
        model = 0;
      else if (e) begin
        model = model + longint'(xs);
        if (model > 64'sd2147483647) model = 64'sd2147483647;
        if (model < -64'sd2147483648) model = -64'sd2147483648;
      end
      check($sformatf("rand%0d", i), y, 32'(model));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/circuit.md
Name: circuit

Overview:
- Enable-gated signed accumulator.
- Each cycle `en` is high, the signed input sample `x` is added to a running sum; the sum is presented on `y`.
- Saturating arithmetic: the sum clamps at the signed range limits and never wraps.
- Sits as a standalone datapath block fed by a sample source that pulses `en` once per valid sample.

Parameters:
- DATA_W, 32, width of `x`, `y` and the internal accumulator (two's complement).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset; sampled on rising edge of clk.
- en  input  1  sample-valid strobe; `x` is consumed on every rising edge where en=1.
- x  input  DATA_W  signed two's-complement sample.
- y  output  DATA_W  signed accumulated sum, driven directly from the accumulator register.

Behaviour:
- State is a single DATA_W-bit signed register `acc`; y = acc at all times (registered output, no combinational path from x or en to y).
- Reset:
  - on a rising edge with rst=1, acc <= 0 regardless of en or x.
  - rst has priority over en.
  - y reads 0 from the cycle after that edge.
- Reset mid-operation discards the accumulated value; accumulation restarts from 0 on the first en after rst deasserts.
- Accumulate: on a rising edge with rst=0 and en=1, acc <= sat(acc + x).
  - Latency 1: y shows the new sum in the cycle following the en edge.
- Hold: on a rising edge with rst=0 and en=0, acc holds; x is ignored (may be X/undefined without affecting acc).
- Arithmetic:
  - Sum computed at DATA_W+1 bits with sign extension of both operands.
  - sat() clamps: result > 2^(DATA_W-1)-1 gives MAX = 0x7FFFFFFF for DATA_W=32; result < -2^(DATA_W-1) gives MIN = 0x80000000; otherwise the result is truncated to DATA_W bits.
  - Overflow detection: both operands same sign and truncated result of opposite sign.
- Saturation is sticky only in value: after clamping at MAX, adding a negative x decreases normally from MAX (no latched flag).
- Back-to-back en (every cycle) is supported at full rate; each asserted cycle adds exactly one sample.
- No handshake beyond en; the block is always ready.
- Power-up before the first reset is undefined; the bench must apply rst first.

Test Plan:
- Reset: hold rst=1 for 2 cycles with en=1, x=5 -> y=0 throughout and one cycle after rst falls; acc unchanged by en while rst=1.
- Basic accumulate: en pulsed one cycle in every two with x=3, -7, 10, 0 -> y sequence 3, -4, 6, 6, each updating one cycle after its en edge and holding in the en=0 cycles.
- Ignore when disabled: en=0 for 5 cycles while x toggles 19, -19, 12 -> y stays at its prior value.
- Positive saturation:
  - preload by adding x=0x7FFFFFF0, then x=0x20 -> y=0x7FFFFFFF;
  - then x=-1 -> y=0x7FFFFFFE.
- Negative saturation: from 0, add x=0x80000000, then x=-5 -> y=0x80000000; then x=+5 -> y=0x80000005.
- Random stream plus mid-run reset:
  - 100 samples of x in -19..19, en alternating 1/0, y checked each cycle against a reference model sum;
  - assert rst at sample 50 -> y=0 next cycle; model resumes from 0.
